// File: rtl/threshold_zone_monitor_pkg.sv
// -----------------------------------------------------------------------------
// threshold_zone_monitor_pkg
// Shared definitions for the threshold zone monitor:
//   - zone_e : zone encoding (INSIDE / BELOW / ABOVE; 2'b11 is never produced)
//   - signed_bits() : two's complement width needed to hold an integer
//   - cmp_width()   : width in which a sample and both thresholds can be
//                     compared with no truncation
// -----------------------------------------------------------------------------
package threshold_zone_monitor_pkg;

    typedef enum logic [1:0] {
        ZONE_INSIDE = 2'b00,
        ZONE_BELOW  = 2'b01,
        ZONE_ABOVE  = 2'b10
    } zone_e;

    // Smallest two's complement width that holds v.
    function automatic int signed_bits(input int v);
        for (int n = 1; n < 32; n++) begin
            if ((longint'(v) >= -(64'sd1 <<< (n - 1))) &&
                (longint'(v) <= ((64'sd1 <<< (n - 1)) - 64'sd1))) begin
                return n;
            end
        end
        return 32;
    endfunction

    // Comparison width: wide enough for the sample and both thresholds as
    // signed values, plus one bit so a zero-extended unsigned sample never
    // reads back as negative.
    function automatic int cmp_width(input int width, input int lo, input int hi);
        int w;
        w = width;
        if (signed_bits(lo) > w) begin
            w = signed_bits(lo);
        end
        if (signed_bits(hi) > w) begin
            w = signed_bits(hi);
        end
        return w + 1;
    endfunction

endpackage

// File: rtl/threshold_zone_monitor_if.sv
// -----------------------------------------------------------------------------
// threshold_zone_monitor_if
// Sample/result bundle of the threshold zone monitor.
//   in_valid, a, clr          : producer -> monitor
//   zone, alarm, changed,
//   viol_cnt                  : monitor -> consumer
// Modports: master (sample producer / observer), slave (the monitor).
// -----------------------------------------------------------------------------
interface threshold_zone_monitor_if
    import threshold_zone_monitor_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic             clr;
    zone_e            zone;
    logic             alarm;
    logic             changed;
    logic [CNT_W-1:0] viol_cnt;

    modport master (
        output in_valid, a, clr,
        input  zone, alarm, changed, viol_cnt
    );

    modport slave (
        input  in_valid, a, clr,
        output zone, alarm, changed, viol_cnt
    );
endinterface

// File: rtl/threshold_zone_monitor_zone_classify.sv
// -----------------------------------------------------------------------------
// zone_classify
// Purely combinational classification of one sample against constant
// thresholds: BELOW if a < LO, else ABOVE if a > HI, else INSIDE.
//   i_a     : WIDTH-bit sample (two's complement when SIGNED != 0)
//   o_class : zone_e classification
// Both sides are brought to a common signed width first, so thresholds at or
// outside the sample range fold to constant true/false comparisons.
// -----------------------------------------------------------------------------
module zone_classify
    import threshold_zone_monitor_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0,
    parameter int LO     = 4,
    parameter int HI     = 11
)(
    input  logic [WIDTH-1:0] i_a,
    output zone_e            o_class
);
    localparam int CW = cmp_width(WIDTH, LO, HI);
    localparam logic signed [CW-1:0] LO_C = CW'(LO);
    localparam logic signed [CW-1:0] HI_C = CW'(HI);

    logic signed [CW-1:0] w_a_ext;

    if (SIGNED != 0) begin : g_sext
        assign w_a_ext = {{(CW - WIDTH){i_a[WIDTH-1]}}, i_a};
    end else begin : g_zext
        assign w_a_ext = {{(CW - WIDTH){1'b0}}, i_a};
    end

    // Threshold comparison, BELOW taking precedence over ABOVE.
    always_comb begin
        o_class = ZONE_INSIDE;
        if (w_a_ext < LO_C) begin
            o_class = ZONE_BELOW;
        end else if (w_a_ext > HI_C) begin
            o_class = ZONE_ABOVE;
        end else begin
            o_class = ZONE_INSIDE;
        end
    end
endmodule

// File: rtl/threshold_zone_monitor.sv
// -----------------------------------------------------------------------------
// threshold_zone_monitor
// Classifies each valid sample, debounces the class over HOLD consecutive
// valid samples into a stable zone, and counts out-of-range samples.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : in_valid, a, clr in; zone, alarm, changed, viol_cnt out
// All outputs are registered.
// -----------------------------------------------------------------------------
module threshold_zone_monitor
    import threshold_zone_monitor_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0,
    parameter int LO     = 4,
    parameter int HI     = 11,
    parameter int HOLD   = 3,
    parameter int CNT_W  = 8
)(
    input  logic                    clk,
    input  logic                    rst_n,
    threshold_zone_monitor_if.slave bus
);
    localparam int RUN_W = $clog2(HOLD + 1);
    localparam logic [RUN_W-1:0] HOLD_R = RUN_W'(HOLD);

    zone_e            w_class;
    zone_e            r_zone, w_zone_nxt;
    zone_e            r_cand, w_cand_nxt;
    logic [RUN_W-1:0] r_run, w_run_nxt, w_run_inc;
    logic             r_alarm;
    logic             r_changed, w_changed_nxt;
    logic [CNT_W-1:0] r_viol, w_viol_nxt;

    zone_classify #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED),
        .LO     (LO),
        .HI     (HI)
    ) u_classify (
        .i_a     (bus.a),
        .o_class (w_class)
    );

    assign w_run_inc = r_run + RUN_W'(1);

    // Debounce next-state: a run only grows on an unbroken streak of the
    // candidate class; a run of 0 means no streak is in progress.
    always_comb begin
        w_zone_nxt    = r_zone;
        w_cand_nxt    = r_cand;
        w_run_nxt     = r_run;
        w_changed_nxt = 1'b0;
        if (bus.in_valid) begin
            if (w_class == r_zone) begin
                w_run_nxt = '0;
            end else if ((w_class == r_cand) && (r_run != '0)) begin
                if (w_run_inc == HOLD_R) begin
                    w_zone_nxt    = w_class;
                    w_run_nxt     = '0;
                    w_changed_nxt = 1'b1;
                end else begin
                    w_run_nxt = w_run_inc;
                end
            end else begin
                w_cand_nxt = w_class;
                if (HOLD == 1) begin
                    w_zone_nxt    = w_class;
                    w_run_nxt     = '0;
                    w_changed_nxt = 1'b1;
                end else begin
                    w_run_nxt = RUN_W'(1);
                end
            end
        end else begin
            w_run_nxt = r_run;
        end
    end

    // Violation counter next value: clear wins over increment, saturates.
    always_comb begin
        w_viol_nxt = r_viol;
        if (bus.clr) begin
            w_viol_nxt = '0;
        end else if (bus.in_valid && (w_class != ZONE_INSIDE) && (r_viol != '1)) begin
            w_viol_nxt = r_viol + CNT_W'(1);
        end else begin
            w_viol_nxt = r_viol;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zone    <= ZONE_INSIDE;
            r_cand    <= ZONE_INSIDE;
            r_run     <= '0;
            r_alarm   <= 1'b0;
            r_changed <= 1'b0;
            r_viol    <= '0;
        end else begin
            r_zone    <= w_zone_nxt;
            r_cand    <= w_cand_nxt;
            r_run     <= w_run_nxt;
            r_alarm   <= (w_zone_nxt != ZONE_INSIDE);
            r_changed <= w_changed_nxt;
            r_viol    <= w_viol_nxt;
        end
    end

    assign bus.zone     = r_zone;
    assign bus.alarm    = r_alarm;
    assign bus.changed  = r_changed;
    assign bus.viol_cnt = r_viol;
endmodule

// File: doc/threshold_zone_monitor.md
Name: threshold_zone_monitor

Overview:
- Registered stage that consumes raw sample words and classifies each against constant LO/HI thresholds as BELOW, INSIDE or ABOVE.
- Debounces the classification over HOLD consecutive valid samples and publishes a stable zone, an alarm flag, a change pulse and a saturating violation counter.
- Threshold constants may sit at or beyond the representable range of the sample. Comparisons against such constants must reduce to constant true/false, and the block stays correct when they do.

Parameters:
- WIDTH, 4, sample width in bits.
- SIGNED, 0, 1 = samples and thresholds compared as two's complement.
- LO, 4, lower threshold integer; sample < LO is BELOW; LO <= HI required.
- HI, 11, upper threshold integer; sample > HI is ABOVE; may exceed 2^WIDTH-1 (ABOVE then unreachable).
- HOLD, 3, consecutive valid samples of a new class required to change zone; HOLD >= 1.
- CNT_W, 8, violation counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample qualifier.
- a  input  WIDTH  sample, interpreted per SIGNED.
- clr  input  1  synchronous clear of viol_cnt.
- zone  output  2  debounced zone: 00 INSIDE, 01 BELOW, 10 ABOVE (11 never driven).
- alarm  output  1  registered, 1 when zone != INSIDE.
- changed  output  1  one-cycle pulse in the cycle after zone updates.
- viol_cnt  output  CNT_W  saturating count of valid out-of-range samples (raw, not debounced).

Behaviour:
- Reset (rst_n low, asynchronous, any cycle, including mid-debounce):
  - zone=INSIDE, alarm=0, changed=0, viol_cnt=0.
  - Internal cand=INSIDE, run=0.
  - First edge after release behaves as normal operation.
- Classification (combinational on a):
  - BELOW if a < LO, else ABOVE if a > HI, else INSIDE.
  - Thresholds are extended to max(WIDTH, width needed to hold LO/HI) before comparing, so no truncation occurs.
  - Unsigned, LO=0: BELOW is constant false.
  - Unsigned, HI >= 2^WIDTH-1: ABOVE is constant false.
  - Signed: same rules at -2^(WIDTH-1) and 2^(WIDTH-1)-1.
- Debounce, evaluated on every edge with in_valid=1 and class c; run width = clog2(HOLD+1):
  - c == zone: run<=0.
  - c != zone and c == cand and run != 0: run<=run+1; if run+1 == HOLD then zone<=c, run<=0, changed<=1.
  - Otherwise: cand<=c, run<=1; if HOLD==1 then zone<=c, run<=0, changed<=1.
  - in_valid=0: cand, run and zone hold. Invalid gaps neither advance nor break a run.
  - A BELOW->ABOVE jump restarts the run with the new candidate and never passes through INSIDE.
- Outputs and latency:
  - zone and alarm are registered and reflect the HOLD-th qualifying sample one cycle after the edge that captured it.
  - changed is 1 only in the cycle zone takes a new value, else 0.
- viol_cnt, per edge:
  - clr=1: viol_cnt<=0. clr has priority over a simultaneous increment, which is dropped.
  - Else if in_valid and c != INSIDE and viol_cnt != all-ones: viol_cnt<=viol_cnt+1.
  - At all-ones the counter holds (saturates, no wrap).

Decomposition:
- Shared package holds:
  - zone encoding constants ZONE_INSIDE=2'b00, ZONE_BELOW=2'b01, ZONE_ABOVE=2'b10.
  - A function returning the extended comparison width from WIDTH, LO and HI.
- One natural sub-module, zone_classify: purely combinational, parameters WIDTH/SIGNED/LO/HI, input a, output class[1:0].
  - It is the constant-comparison stage and is also synthesised standalone to check constant folding.
- Debounce FSM and counter live in the top.

Test Plan:
- Defaults: reset, then valid a=2,2,2 -> zone 00 until the third sample, then zone=01 and alarm=1 one cycle after the third edge; changed=1 for exactly that cycle; viol_cnt=3.
- Run broken by a class change: zone=INSIDE, samples a=12,12,1,12,12,12 -> the first two ABOVE are discarded; the BELOW at a=1 sets run=1 with no change; zone=10 only after the final three 12s; viol_cnt=6.
- Invalid gaps: a=0 valid, idle 5 cycles, a=0 valid, idle, a=0 valid -> zone=01 after the third valid sample; no change during idle.
- Boundaries: LO=0, HI=15, WIDTH=4, sweep a=0..15 -> zone stays 00, viol_cnt=0, changed never asserts. SIGNED=1, LO=-8, HI=7 -> same result.
- Saturation/clr: CNT_W=3, 9 valid a=15 samples -> viol_cnt sticks at 7. clr=1 together with a valid a=15 -> viol_cnt=0 next cycle.
- Async reset after two of three BELOW samples: drop rst_n mid-cycle -> all outputs 0 immediately. After release, a single a=2 does not change zone (run restarted).
